// File: rtl/clk_divider_multi.sv
// Multi-channel programmable clock-enable generator. Each channel emits a divided waveform and a
// period-start tick; new period/high settings are staged in a shadow and applied at the next wrap.
module clk_divider_multi #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned CNT_WIDTH   = 24,
  parameter int unsigned DEFAULT_DIV = 12000000
) (
  input  logic                                                 clk_in,
  input  logic                                                 rst_n,
  input  logic [CHANNELS-1:0]                                  en,
  input  logic                                                 cfg_valid,
  output logic                                                 cfg_ready,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_ch,
  input  logic [CNT_WIDTH-1:0]                                 cfg_div,
  input  logic [CNT_WIDTH-1:0]                                 cfg_high,
  output logic [CHANNELS-1:0]                                  clk_out,
  output logic [CHANNELS-1:0]                                  tick
);

  localparam int unsigned ChW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef logic [CNT_WIDTH-1:0] cnt_t;

  localparam cnt_t DefDiv  = cnt_t'(DEFAULT_DIV);
  localparam cnt_t DefHigh = cnt_t'(DEFAULT_DIV / 2);
  localparam cnt_t One     = cnt_t'(1);
  localparam cnt_t Two     = cnt_t'(2);

  logic [CHANNELS-1:0] pending;
  cnt_t                div_clamp;
  cnt_t                high_clamp;
  logic                accept;

  // Clamp so that both the high and the low phase are at least one cycle long.
  always_comb begin
    div_clamp = (cfg_div < Two) ? Two : cfg_div;
    if (cfg_high == '0) begin
      high_clamp = One;
    end else if (cfg_high >= div_clamp) begin
      high_clamp = div_clamp - One;
    end else begin
      high_clamp = cfg_high;
    end
  end

  // Out-of-range channel indices never match a channel, so ready stays low for them.
  always_comb begin
    cfg_ready = 1'b0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (cfg_ch == ChW'(i)) begin
        cfg_ready = !pending[i];
      end
    end
  end

  assign accept = cfg_valid && cfg_ready;

  for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_ch
    cnt_t p_q, p_d;
    cnt_t h_q, h_d;
    cnt_t c_q, c_d;
    cnt_t sp_q, sp_d;
    cnt_t sh_q, sh_d;
    logic pend_q, pend_d;
    logic clk_q, clk_d;
    logic tick_q, tick_d;
    logic wr;

    assign wr = accept && (cfg_ch == ChW'(g));

    always_comb begin
      p_d    = p_q;
      h_d    = h_q;
      c_d    = c_q;
      sp_d   = sp_q;
      sh_d   = sh_q;
      pend_d = pend_q;
      clk_d  = 1'b0;
      tick_d = 1'b0;

      // A write is only accepted while nothing is pending, so it never collides with a load.
      if (wr) begin
        sp_d   = div_clamp;
        sh_d   = high_clamp;
        pend_d = 1'b1;
      end

      if (!en[g]) begin
        if (pend_q) begin
          p_d    = sp_q;
          h_d    = sh_q;
          pend_d = 1'b0;
        end
        // Parking at P-1 makes the first enabled edge a period start.
        c_d = p_d - One;
      end else if (c_q == p_q - One) begin
        if (pend_q) begin
          p_d    = sp_q;
          h_d    = sh_q;
          pend_d = 1'b0;
        end
        c_d    = '0;
        clk_d  = 1'b1;
        tick_d = 1'b1;
      end else begin
        c_d   = c_q + One;
        clk_d = (c_d < h_q);
      end
    end

    always_ff @(posedge clk_in) begin
      if (!rst_n) begin
        p_q    <= DefDiv;
        h_q    <= DefHigh;
        c_q    <= DefDiv - One;
        sp_q   <= DefDiv;
        sh_q   <= DefHigh;
        pend_q <= 1'b0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        p_q    <= p_d;
        h_q    <= h_d;
        c_q    <= c_d;
        sp_q   <= sp_d;
        sh_q   <= sh_d;
        pend_q <= pend_d;
        clk_q  <= clk_d;
        tick_q <= tick_d;
      end
    end

    assign pending[g] = pend_q;
    assign clk_out[g] = clk_q;
    assign tick[g]    = tick_q;
  end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Scoreboard bench for clk_divider_multi: stimulus queues expected outputs each cycle, a negedge
// monitor pops and compares them.
module tb_clk_divider_multi;

  logic       clk_in;
  logic       rst_n;
  logic [3:0] en;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div;
  logic [7:0] cfg_high;
  logic [3:0] clk_out;
  logic [3:0] tick;

  // Three-channel instance so that an out-of-range channel index is representable.
  logic [2:0] en3;
  logic       cfg_valid3;
  logic       ready3;
  logic [1:0] cfg_ch3;
  logic [2:0] clk_out3;
  logic [2:0] tick3;

  clk_divider_multi #(
    .CHANNELS   (4),
    .CNT_WIDTH  (8),
    .DEFAULT_DIV(10)
  ) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .en       (en),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_high (cfg_high),
    .clk_out  (clk_out),
    .tick     (tick)
  );

  clk_divider_multi #(
    .CHANNELS   (3),
    .CNT_WIDTH  (8),
    .DEFAULT_DIV(10)
  ) dut3 (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .en       (en3),
    .cfg_valid(cfg_valid3),
    .cfg_ready(ready3),
    .cfg_ch   (cfg_ch3),
    .cfg_div  (cfg_div),
    .cfg_high (cfg_high),
    .clk_out  (clk_out3),
    .tick     (tick3)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    string      name;
    int         kind;  // 0 clk_out, 1 tick, 2 cfg_ready, 3 ready of 3-channel instance
    logic [3:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Expected period, high time and cycles-since-period-start per channel.
  int pp[4] = '{1, 1, 1, 1};
  int hh[4] = '{1, 1, 1, 1};
  int kk[4] = '{0, 0, 0, 0};

  always @(negedge clk_in) begin : mon
    exp_t       e;
    logic [3:0] act;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.kind)
        0:       act = clk_out;
        1:       act = tick;
        2:       act = {3'b000, cfg_ready};
        default: act = {3'b000, ready3};
      endcase
      n_cmp++;
      if (act !== e.exp) begin
        n_err++;
        $display("FAIL %s kind=%0d got=%b want=%b at %0t", e.name, e.kind, act, e.exp, $time);
      end
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push_outputs(input string name, input logic [3:0] act);
    logic [3:0] ec;
    logic [3:0] et;
    for (int i = 0; i < 4; i++) begin
      ec[i] = act[i] && ((kk[i] % pp[i]) < hh[i]);
      et[i] = act[i] && ((kk[i] % pp[i]) == 0);
    end
    sb_q.push_back('{name: {name, "_clk"}, kind: 0, exp: ec});
    sb_q.push_back('{name: {name, "_tick"}, kind: 1, exp: et});
  endtask

  task automatic push_rdy(input string name, input logic v);
    sb_q.push_back('{name: name, kind: 2, exp: {3'b000, v}});
  endtask

  task automatic push_rdy3(input string name, input logic v);
    sb_q.push_back('{name: name, kind: 3, exp: {3'b000, v}});
  endtask

  initial begin
    rst_n      = 1'b0;
    en         = 4'b0000;
    cfg_valid  = 1'b0;
    cfg_ch     = 2'd0;
    cfg_div    = 8'd0;
    cfg_high   = 8'd0;
    en3        = 3'b000;
    cfg_valid3 = 1'b0;
    cfg_ch3    = 2'd0;

    step();
    step();
    push_outputs("reset", 4'b0000);
    push_rdy("reset_rdy", 1'b1);

    // 1: default 10-cycle period on ch0
    rst_n = 1'b1;
    en    = 4'b0001;
    pp[0] = 10;
    hh[0] = 5;
    for (int k = 0; k < 20; k++) begin
      step();
      kk[0] = k;
      push_outputs("t1_ch0", 4'b0001);
      push_rdy("t1_rdy", 1'b1);
    end

    // 2: configure ch1 while disabled
    en        = 4'b0000;
    cfg_valid = 1'b1;
    cfg_ch    = 2'd1;
    cfg_div   = 8'd5;
    cfg_high  = 8'd2;
    push_rdy("t2_rdy_pre", 1'b1);
    step();
    cfg_valid = 1'b0;
    push_outputs("t2_off", 4'b0000);
    push_rdy("t2_rdy_busy", 1'b0);
    step();
    push_outputs("t2_off2", 4'b0000);
    push_rdy("t2_rdy_free", 1'b1);
    en    = 4'b0010;
    pp[1] = 5;
    hh[1] = 2;
    for (int k = 0; k < 15; k++) begin
      step();
      kk[1] = k;
      push_outputs("t2_ch1", 4'b0010);
      push_rdy("t2_rdy", 1'b1);
    end

    // 3: reconfigure ch0 mid-period; change lands at the wrap
    en = 4'b0000;
    step();
    push_outputs("t3_off", 4'b0000);
    en     = 4'b0001;
    cfg_ch = 2'd0;
    pp[0]  = 10;
    hh[0]  = 5;
    for (int k = 0; k < 23; k++) begin
      step();
      if (k >= 10) begin
        kk[0] = k - 10;
        pp[0] = 4;
        hh[0] = 1;
      end else begin
        kk[0] = k;
      end
      push_outputs("t3_ch0", 4'b0001);
      if (k == 2) begin
        cfg_valid = 1'b1;
        cfg_div   = 8'd4;
        cfg_high  = 8'd1;
        push_rdy("t3_rdy_pre", 1'b1);
      end else begin
        cfg_valid = 1'b0;
        push_rdy("t3_rdy", !(k >= 3 && k <= 9));
      end
    end

    // 4: clamping, plus out-of-range index on the 3-channel instance
    en         = 4'b0000;
    cfg_valid  = 1'b1;
    cfg_ch     = 2'd2;
    cfg_div    = 8'd0;
    cfg_high   = 8'd0;
    cfg_valid3 = 1'b1;
    cfg_ch3    = 2'd3;
    push_rdy("t4_rdy_ch2", 1'b1);
    push_rdy3("t4_oor0", 1'b0);
    step();
    push_outputs("t4_off", 4'b0000);
    push_rdy3("t4_oor1", 1'b0);
    cfg_ch   = 2'd3;
    cfg_div  = 8'd6;
    cfg_high = 8'd9;
    push_rdy("t4_rdy_ch3", 1'b1);
    step();
    push_outputs("t4_off2", 4'b0000);
    push_rdy3("t4_oor2", 1'b0);
    cfg_valid = 1'b0;
    push_rdy("t4_rdy_ch3_busy", 1'b0);
    step();
    push_outputs("t4_off3", 4'b0000);
    push_rdy("t4_rdy_ch3_free", 1'b1);
    cfg_valid3 = 1'b0;
    cfg_ch3    = 2'd2;
    push_rdy3("t4_inrange", 1'b1);
    en    = 4'b1100;
    pp[2] = 2;
    hh[2] = 1;
    pp[3] = 6;
    hh[3] = 5;
    for (int k = 0; k < 12; k++) begin
      step();
      kk[2] = k;
      kk[3] = k;
      push_outputs("t4_clamp", 4'b1100);
    end

    // 5: drop en[0] mid-period, then restart
    en = 4'b0000;
    step();
    push_outputs("t5_off", 4'b0000);
    en    = 4'b0001;
    pp[0] = 4;
    hh[0] = 1;
    for (int k = 0; k < 6; k++) begin
      step();
      kk[0] = k;
      push_outputs("t5_run", 4'b0001);
    end
    en = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      step();
      push_outputs("t5_hold", 4'b0000);
    end
    en = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      step();
      kk[0] = k;
      push_outputs("t5_restart", 4'b0001);
    end

    // 6: reset while a write is pending discards it
    cfg_valid = 1'b1;
    cfg_ch    = 2'd0;
    cfg_div   = 8'd7;
    cfg_high  = 8'd3;
    push_rdy("t6_rdy_pre", 1'b1);
    step();
    kk[0] = 8;
    push_outputs("t6_run", 4'b0001);
    cfg_valid = 1'b0;
    push_rdy("t6_busy", 1'b0);
    rst_n = 1'b0;
    step();
    push_outputs("t6_reset", 4'b0000);
    push_rdy("t6_rdy_after_rst", 1'b1);
    rst_n = 1'b1;
    en    = 4'b0011;
    pp[0] = 10;
    hh[0] = 5;
    pp[1] = 10;
    hh[1] = 5;
    for (int k = 0; k < 12; k++) begin
      step();
      kk[0] = k;
      kk[1] = k;
      push_outputs("t6_default", 4'b0011);
      push_rdy("t6_rdy", 1'b1);
    end

    @(negedge clk_in);
    #1;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain left=%0d want=0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
